sd_init_ctrl: RTL and testbench

Sequences the SD transceiver through the card identification and initialisation flow: CMD0, CMD8, the CMD55/ACMD41 loop, CMD2, CMD3, CMD7, and CMD55/ACMD6 for the 4-bit bus.
Drives the transceiver command inputs (istart, icmd_index, icmd_arg, isel_clk) and checks each response.
On success it switches the transceiver to the 18 MHz clock and reports ready with the card RCA. It sits between the top-level GOST/SD controller and the transceiver.

---
 rtl/sd_pkg.sv | 31 +++
 rtl/sd_init_ctrl_if.sv | 25 ++
 rtl/sd_cmd_issuer.sv | 93 +++++++++
 rtl/sd_init_ctrl.sv | 104 ++++++++++
 tb/tb_sd_init_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: command/argument constants and state types shared by the SD init controller
package sd_pkg;
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD3   = 6'd3;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD6  = 6'd6;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
    localparam logic [31:0] ARG_ACMD41 = 32'h40FF_8000;
    localparam logic [31:0] ARG_BUS4   = 32'h0000_0002;
    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD0, ST_CMD8, ST_CMD55A, ST_ACMD41, ST_CMD2,
        ST_CMD3, ST_CMD7, ST_CMD55B, ST_ACMD6, ST_READY, ST_FAIL
    } top_state_t;
    typedef enum logic [1:0] {I_IDLE, I_ISSUE, I_WAIT, I_GAP} iss_state_t;
    function automatic logic [5:0] cmd_idx(top_state_t s);
        case (s)
            ST_CMD2:              return CMD2;
            ST_CMD3:              return CMD3;
            ST_CMD7:              return CMD7;
            ST_CMD8:              return CMD8;
            ST_CMD55A, ST_CMD55B: return CMD55;
            ST_ACMD6:             return ACMD6;
            ST_ACMD41:            return ACMD41;
            default:              return CMD0;
        endcase
    endfunction
endpackage

// File: rtl/sd_init_ctrl_if.sv
// sd_init_ctrl_if: control handshake and transceiver command/response bundle
// slave  (the controller): istart/iresp/icrc_fail/ivalid in; command, start, clock select and status out
// master (controller user + transceiver side): the opposite directions
interface sd_init_ctrl_if;
    logic        istart;
    logic        otrx_start;
    logic        osel_clk;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;
    logic [31:0] iresp;
    logic        icrc_fail;
    logic        ivalid;
    logic        obusy;
    logic        ordy;
    logic        ofail;
    logic [15:0] orca;
    modport slave (
        input  istart, iresp, icrc_fail, ivalid,
        output otrx_start, osel_clk, ocmd_index, ocmd_arg, obusy, ordy, ofail, orca
    );
    modport master (
        output istart, iresp, icrc_fail, ivalid,
        input  otrx_start, osel_clk, ocmd_index, ocmd_arg, obusy, ordy, ofail, orca
    );
endinterface

// File: rtl/sd_cmd_issuer.sv
// sd_cmd_issuer: runs one command as ISSUE/WAIT/GAP with timeout and bounded retry
// go_i starts a command from idle; rej_i/chk_crc_i qualify the response at ivalid_i;
// trx_start_o pulses the transceiver; done_o (with resp_o) or fail_o pulses when finished
module sd_cmd_issuer
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CMD_RETRIES    = 3
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        go_i,
    input  logic        chk_crc_i,
    input  logic        rej_i,
    input  logic        ivalid_i,
    input  logic        icrc_fail_i,
    input  logic [31:0] iresp_i,
    output logic        trx_start_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [31:0] resp_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(CMD_RETRIES + 2);
    iss_state_t    st_q, st_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [RW-1:0] rty_q, rty_d;
    logic          ok_q, ok_d;
    logic [31:0]   resp_q, resp_d;
    logic          expired, retry;
    assign resp_o = resp_q;
    always_comb begin
        st_d        = st_q;
        tmr_d       = tmr_q;
        rty_d       = rty_q;
        ok_d        = ok_q;
        resp_d      = resp_q;
        trx_start_o = 1'b0;
        done_o      = 1'b0;
        fail_o      = 1'b0;
        expired     = tmr_q == TW'(TIMEOUT_CYCLES - 1);
        // ivalid takes priority over a simultaneous timeout
        retry       = ivalid_i ? ((chk_crc_i && icrc_fail_i) || rej_i) : expired;
        case (st_q)
            I_IDLE: begin
                rty_d = '0;
                st_d  = go_i ? I_ISSUE : I_IDLE;
            end
            I_ISSUE: begin
                trx_start_o = 1'b1;
                tmr_d       = '0;
                st_d        = I_WAIT;
            end
            I_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (ivalid_i || expired) begin
                    if (!retry) begin
                        ok_d   = 1'b1;
                        resp_d = iresp_i;
                        st_d   = I_GAP;
                    end else if (rty_q == RW'(CMD_RETRIES)) begin
                        fail_o = 1'b1;
                        st_d   = I_IDLE;
                    end else begin
                        ok_d  = 1'b0;
                        rty_d = rty_q + 1'b1;
                        st_d  = I_GAP;
                    end
                end
            end
            default: begin
                // the gap cycle either hands back the result or re-issues
                done_o = ok_q;
                st_d   = ok_q ? I_IDLE : I_ISSUE;
            end
        endcase
    end
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            st_q   <= I_IDLE;
            tmr_q  <= '0;
            rty_q  <= '0;
            ok_q   <= 1'b0;
            resp_q <= '0;
        end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            rty_q  <= rty_d;
            ok_q   <= ok_d;
            resp_q <= resp_d;
        end
    end
endmodule

// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl: SD card identification/initialisation sequencer driving the transceiver
// iclk/irst: clock and async active-low reset; bus: istart in, command/start/clock select out,
// transceiver response in, obusy/ordy/ofail/orca status out
module sd_init_ctrl
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CMD_RETRIES    = 3,
    parameter int ACMD41_TRIES   = 1000
) (
    input logic          iclk,
    input logic          irst,
    sd_init_ctrl_if.slave bus
);
    localparam int AW = $clog2(ACMD41_TRIES + 1);
    top_state_t  st_q, st_d;
    logic [15:0] rca_q, rca_d;
    logic [AW-1:0] a41_q, a41_d;
    logic        busy, go, done, fail, rej, chk_crc;
    logic [31:0] resp;
    assign busy    = !(st_q inside {ST_IDLE, ST_READY, ST_FAIL});
    assign go      = busy;
    assign chk_crc = !(st_q inside {ST_CMD0, ST_ACMD41});
    // a zero RCA from CMD3 is treated like a corrupted response and retried
    assign rej     = st_q == ST_CMD3 && (bus.iresp & 32'hFFFF_0000) == '0;
    sd_cmd_issuer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CMD_RETRIES   (CMD_RETRIES)
    ) u_iss (
        .iclk       (iclk),
        .irst       (irst),
        .go_i       (go),
        .chk_crc_i  (chk_crc),
        .rej_i      (rej),
        .ivalid_i   (bus.ivalid),
        .icrc_fail_i(bus.icrc_fail),
        .iresp_i    (bus.iresp),
        .trx_start_o(bus.otrx_start),
        .done_o     (done),
        .fail_o     (fail),
        .resp_o     (resp)
    );
    assign bus.obusy      = busy;
    assign bus.ordy       = st_q == ST_READY;
    assign bus.ofail      = st_q == ST_FAIL;
    assign bus.osel_clk   = st_q == ST_READY;
    assign bus.orca       = rca_q;
    assign bus.ocmd_index = cmd_idx(st_q);
    always_comb begin
        bus.ocmd_arg = '0;
        case (st_q)
            ST_CMD8:                       bus.ocmd_arg = ARG_CMD8;
            ST_ACMD41:                     bus.ocmd_arg = ARG_ACMD41;
            ST_ACMD6:                      bus.ocmd_arg = ARG_BUS4;
            ST_CMD55A, ST_CMD7, ST_CMD55B: bus.ocmd_arg = {rca_q, 16'h0};
            default: ;
        endcase
    end
    always_comb begin
        st_d  = st_q;
        rca_d = rca_q;
        a41_d = a41_q;
        if (!busy) begin
            if (bus.istart) begin
                st_d  = ST_CMD0;
                rca_d = '0;
                a41_d = '0;
            end
        end else if (fail) begin
            st_d = ST_FAIL;
        end else if (done) begin
            case (st_q)
                ST_CMD0:   st_d = ST_CMD8;
                ST_CMD8:   st_d = (resp & 32'h0000_0FFF) == ARG_CMD8 ? ST_CMD55A : ST_FAIL;
                ST_CMD55A: st_d = ST_ACMD41;
                ST_ACMD41: begin
                    a41_d = a41_q + 1'b1;
                    st_d  = resp[31] ? ST_CMD2 :
                            a41_q < AW'(ACMD41_TRIES - 1) ? ST_CMD55A : ST_FAIL;
                end
                ST_CMD2:   st_d = ST_CMD3;
                ST_CMD3: begin
                    rca_d = resp[31:16];
                    st_d  = ST_CMD7;
                end
                ST_CMD7:   st_d = ST_CMD55B;
                ST_CMD55B: st_d = ST_ACMD6;
                ST_ACMD6:  st_d = ST_READY;
                default: ;
            endcase
        end
    end
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            st_q  <= ST_IDLE;
            rca_q <= '0;
            a41_q <= '0;
        end else begin
            st_q  <= st_d;
            rca_q <= rca_d;
            a41_q <= a41_d;
        end
    end
endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb_sd_init_ctrl: scoreboard bench with a behavioural SD card model for sd_init_ctrl
module tb_sd_init_ctrl;
    logic clk = 1'b0;
    logic irst;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last7 = -1;
    int   a41_busy = 0;
    int   a41_cnt = 0;
    int   no_answer = -1;
    logic crc2_once = 1'b0;
    logic crc41_once = 1'b0;
    logic [31:0] cmd8_resp = 32'h0000_01AA;
    logic [37:0] exp_q[$];
    logic [37:0] e;
    logic [5:0]  m_idx;
    logic [31:0] m_resp;
    logic        m_crc;
    sd_init_ctrl_if bus();
    sd_init_ctrl #(.TIMEOUT_CYCLES(100), .CMD_RETRIES(3), .ACMD41_TRIES(5)) dut (
        .iclk(clk),
        .irst(irst),
        .bus (bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic push(input logic [5:0] i, input logic [31:0] a);
        exp_q.push_back({i, a});
    endtask
    task automatic push_pre(input int busy_n);
        push(6'd0, 32'h0);
        push(6'd8, 32'h0000_01AA);
        for (int k = 0; k <= busy_n; k++) begin
            push(6'd55, 32'h0);
            push(6'd41, 32'h40FF_8000);
        end
    endtask
    task automatic push_tail();
        push(6'd7, 32'hB368_0000);
        push(6'd55, 32'hB368_0000);
        push(6'd6, 32'h0000_0002);
    endtask
    task automatic start(input string nm);
        a41_cnt = 0;
        @(negedge clk);
        bus.istart = 1'b1;
        @(negedge clk);
        bus.istart = 1'b0;
        chk({nm, "_start_status"}, {bus.obusy, bus.osel_clk, bus.ordy, bus.ofail, bus.orca}, {4'b1000, 16'h0});
    endtask
    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.obusy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_finished"}, bus.obusy, 0);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask
    // monitor: every transceiver start is matched against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (irst && bus.otrx_start) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_start: got cmd %0d arg 0x%0h, expected no start", bus.ocmd_index, bus.ocmd_arg);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_idx_arg", {bus.ocmd_index, bus.ocmd_arg}, e);
                end
                if (bus.ocmd_index == 6'd7) begin
                    if (last7 >= 0) chk("cmd7_gap_ge_100", (cyc - last7) >= 100, 1);
                    last7 = cyc;
                end
            end
        end
    end
    // card model: answers three cycles after each start unless told to stay silent
    initial begin
        bus.ivalid = 1'b0;
        bus.iresp = '0;
        bus.icrc_fail = 1'b0;
        forever begin
            @(negedge clk);
            if (irst && bus.otrx_start) begin
                m_idx = bus.ocmd_index;
                m_crc = 1'b0;
                case (m_idx)
                    6'd8: m_resp = cmd8_resp;
                    6'd41: begin
                        a41_cnt++;
                        m_resp = (a41_busy < 0 || a41_cnt <= a41_busy) ? 32'h00FF_8000 : 32'h80FF_8000;
                        m_crc = crc41_once;
                        crc41_once = 1'b0;
                    end
                    6'd2: begin
                        m_resp = 32'h0;
                        m_crc = crc2_once;
                        crc2_once = 1'b0;
                    end
                    6'd3: m_resp = 32'hB368_0500;
                    default: m_resp = 32'h0000_0120;
                endcase
                if (int'(m_idx) != no_answer) begin
                    repeat (3) @(posedge clk);
                    #1;
                    bus.ivalid = 1'b1;
                    bus.iresp = m_resp;
                    bus.icrc_fail = m_crc;
                    @(posedge clk);
                    #1;
                    bus.ivalid = 1'b0;
                    bus.icrc_fail = 1'b0;
                end
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        irst = 1'b0;
        bus.istart = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.otrx_start, bus.osel_clk, bus.ocmd_index, bus.ocmd_arg, bus.obusy, bus.ordy, bus.ofail, bus.orca}, 0);
        irst = 1'b1;
        // nominal: two busy ACMD41 replies
        a41_busy = 2;
        push_pre(2);
        push(6'd2, 32'h0);
        push(6'd3, 32'h0);
        push_tail();
        start("nominal");
        wait_idle("nominal");
        chk("nominal_ready", {bus.ordy, bus.osel_clk, bus.ofail}, 3'b110);
        chk("nominal_rca", bus.orca, 16'hB368);
        // bad CMD8 echo
        cmd8_resp = 32'h0000_0155;
        push(6'd0, 32'h0);
        push(6'd8, 32'h0000_01AA);
        start("cmd8_bad");
        wait_idle("cmd8_bad");
        chk("cmd8_bad_fail", {bus.ofail, bus.ordy, bus.osel_clk}, 3'b100);
        repeat (50) @(negedge clk);
        chk("cmd8_bad_no_more", exp_q.size(), 0);
        cmd8_resp = 32'h0000_01AA;
        // CRC error on the first CMD2 and first ACMD41
        a41_busy = 0;
        crc2_once = 1'b1;
        crc41_once = 1'b1;
        push_pre(0);
        push(6'd2, 32'h0);
        push(6'd2, 32'h0);
        push(6'd3, 32'h0);
        push_tail();
        start("crc");
        wait_idle("crc");
        chk("crc_ready", {bus.ordy, bus.osel_clk, bus.ofail}, 3'b110);
        // CMD7 never answered
        no_answer = 7;
        last7 = -1;
        push_pre(0);
        push(6'd2, 32'h0);
        push(6'd3, 32'h0);
        for (int k = 0; k < 4; k++) push(6'd7, 32'hB368_0000);
        start("cmd7_timeout");
        wait_idle("cmd7_timeout");
        chk("cmd7_timeout_fail", {bus.ofail, bus.ordy, bus.osel_clk}, 3'b100);
        no_answer = -1;
        // ACMD41 busy forever
        a41_busy = -1;
        push_pre(4);
        start("a41_busy");
        wait_idle("a41_busy");
        chk("a41_busy_fail", {bus.ofail, bus.ordy}, 2'b10);
        chk("a41_busy_count", a41_cnt, 5);
        // asynchronous reset while CMD3 is outstanding, then restart
        a41_busy = 0;
        no_answer = 3;
        push_pre(0);
        push(6'd2, 32'h0);
        push(6'd3, 32'h0);
        start("rst");
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_cmd3_seen", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        #2 irst = 1'b0;
        #1;
        chk("rst_async_outputs", {bus.otrx_start, bus.osel_clk, bus.ocmd_index, bus.ocmd_arg, bus.obusy, bus.ordy, bus.ofail, bus.orca}, 0);
        @(negedge clk);
        irst = 1'b1;
        no_answer = -1;
        push_pre(0);
        push(6'd2, 32'h0);
        push(6'd3, 32'h0);
        push_tail();
        start("restart");
        wait_idle("restart");
        chk("restart_ready", {bus.ordy, bus.osel_clk, bus.ofail, bus.orca}, {3'b110, 16'hB368});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
